// File: rtl/spi_master_mc.sv
// Multi-channel SPI master: round-robin grant among NUM_CH requesters, per-frame length/mode/divider.
// One frame in flight; the latched request parameters are immune to mid-frame input changes.
module spi_master_mc #(
  parameter int NUM_CH  = 2,
  parameter int FRAME_W = 40,
  parameter int LEN_W   = 6,
  parameter int DIV_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*FRAME_W-1:0] tx_data,
  input  logic [NUM_CH*LEN_W-1:0]   tx_len,
  output logic [NUM_CH-1:0]         ack,
  input  logic [DIV_W-1:0]          clk_div,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      miso,
  output logic                      sclk,
  output logic                      mosi,
  output logic [NUM_CH-1:0]         cs_b,
  output logic [FRAME_W-1:0]        rx_data,
  output logic                      rx_valid,
  output logic [2:0]                rx_ch,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  localparam logic [3:0]       NCH     = 4'(NUM_CH);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(FRAME_W - 1);

  state_t             state;
  logic [DIV_W-1:0]   div_q, cnt;
  logic               cpol_q, cpha_q;
  logic [LEN_W+1:0]   edge_cnt, edge_last;
  logic [FRAME_W-1:0] tx_sr, rx_sr;
  logic [2:0]         ptr, cur_ch;

  logic [7:0]         req_ext;
  logic               gnt_vld;
  logic [2:0]         gnt;
  logic [3:0]         idx;
  logic [NUM_CH-1:0]  gnt_oh;
  logic [FRAME_W-1:0] sel_data, aligned;
  logic [LEN_W-1:0]   sel_len, len_c;
  logic [LEN_W+1:0]   n_bits;
  logic [3:0]         nxt4;
  logic [2:0]         nxt_ptr;

  assign req_ext = 8'(req);

  // Lowest rotation offset from ptr wins, so the search starts at ptr itself.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= NCH) idx = idx - NCH;
      if (req_ext[idx[2:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[2:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    gnt_oh   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      gnt_oh[k] = (gnt == 3'(k));
      if (gnt == 3'(k)) begin
        sel_data = tx_data[k*FRAME_W +: FRAME_W];
        sel_len  = tx_len[k*LEN_W +: LEN_W];
      end
    end
    len_c   = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
    aligned = sel_data << (LEN_MAX - len_c);
    n_bits  = (LEN_W+2)'(len_c) + (LEN_W+2)'(1);
    nxt4    = {1'b0, gnt} + 4'd1;
    if (nxt4 >= NCH) nxt4 = '0;
    nxt_ptr = nxt4[2:0];
  end

  logic             hit, edge_now, lead_edge, last_edge, samp, drive;
  logic [LEN_W+1:0] edge_num;

  // Edge 1 is produced on the last LEAD cycle; SHIFT then spans 2N half-periods.
  assign hit       = (cnt == div_q);
  assign edge_num  = (state == LEAD) ? (LEN_W+2)'(1) : edge_cnt + (LEN_W+2)'(1);
  assign edge_now  = hit && ((state == LEAD) || (state == SHIFT && edge_cnt != edge_last));
  assign lead_edge = edge_num[0];
  assign last_edge = (edge_num == edge_last);
  assign samp      = edge_now && (lead_edge ^ cpha_q);
  assign drive     = edge_now && (cpha_q ? lead_edge : (!lead_edge && !last_edge));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_q     <= '0;
      cnt       <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      edge_cnt  <= '0;
      edge_last <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      ptr       <= '0;
      cur_ch    <= '0;
      ack       <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_b      <= '1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_ch     <= '0;
      busy      <= 1'b0;
    end else begin
      ack      <= '0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (gnt_vld) begin
          ack       <= gnt_oh;
          cs_b      <= ~gnt_oh;
          cur_ch    <= gnt;
          ptr       <= nxt_ptr;
          div_q     <= clk_div;
          cpol_q    <= cpol;
          cpha_q    <= cpha;
          sclk      <= cpol;
          edge_last <= n_bits << 1;
          edge_cnt  <= '0;
          cnt       <= '0;
          rx_sr     <= '0;
          busy      <= 1'b1;
          state     <= LEAD;
          if (!cpha) begin
            mosi  <= aligned[FRAME_W-1];
            tx_sr <= aligned << 1;
          end else begin
            tx_sr <= aligned;
          end
        end
        LEAD: if (hit) begin
          cnt      <= '0;
          edge_cnt <= (LEN_W+2)'(1);
          state    <= SHIFT;
        end else cnt <= cnt + DIV_W'(1);
        SHIFT: if (hit) begin
          cnt <= '0;
          if (edge_cnt == edge_last) state <= TRAIL;
          else edge_cnt <= edge_num;
        end else cnt <= cnt + DIV_W'(1);
        TRAIL: if (hit) begin
          cnt      <= '0;
          cs_b     <= '1;
          rx_valid <= 1'b1;
          rx_data  <= rx_sr;
          rx_ch    <= cur_ch;
          state    <= GAP;
        end else cnt <= cnt + DIV_W'(1);
        GAP: if (hit) begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + DIV_W'(1);
        default: state <= IDLE;
      endcase
      if (edge_now) sclk <= lead_edge ? ~cpol_q : cpol_q;
      if (samp) rx_sr <= {rx_sr[FRAME_W-2:0], miso};
      if (drive) begin
        mosi  <= tx_sr[FRAME_W-1];
        tx_sr <= tx_sr << 1;
      end
    end
  end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised multi-channel SPI master. It is the successor to the team's fixed 40-bit, two-target SPI controller.
- Arbitrates among NUM_CH requesters (config, DAC, future ADC/mux targets) with round-robin priority.
- Each requester owns a dedicated active-low chip select.
- Frame length is per request. SCLK is divided from clk. Mode (CPOL/CPHA) is per transaction.
- Full-duplex MISO capture, returned with a valid pulse and channel tag.

Parameters:
NUM_CH, 2, number of requesters / chip selects (1..8)
FRAME_W, 40, maximum frame length in bits
LEN_W, 6, width of length field; must satisfy 2^LEN_W >= FRAME_W
DIV_W, 8, width of SCLK divider input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  NUM_CH  level request per channel
tx_data  in  NUM_CH*FRAME_W  per-channel frame, channel k at [k*FRAME_W +: FRAME_W]
tx_len  in  NUM_CH*LEN_W  per-channel frame length minus 1 (0 => 1 bit)
ack  out  NUM_CH  one-cycle pulse: channel's tx_data/tx_len latched; requester pops its FIFO
clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
miso  in  1  serial input
sclk  out  1  serial clock
mosi  out  1  serial output, MSB (bit tx_len) first
cs_b  out  NUM_CH  active-low chip selects, at most one low
rx_data  out  FRAME_W  received bits, right-aligned, upper bits zero
rx_valid  out  1  one-cycle pulse, rx_data/rx_ch valid
rx_ch  out  3  channel index of completed frame
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous): all cs_b=1, sclk=0, mosi=0, ack=0, rx_valid=0, rx_data=0, rx_ch=0, busy=0, state=IDLE, round-robin pointer=0. Reset mid-frame aborts at once: no rx_valid, no further ack.
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE. Let H = clk_div+1 and N = tx_len+1.
- IDLE grant: any req bit high selects granted channel g, the first requester at or after (last_grant+1) mod NUM_CH (round-robin).
- Edge leaving IDLE: ack[g]=1 for exactly one cycle. Latch tx_data[g] (MSB aligned), tx_len[g], clk_div, cpol, cpha. cs_b[g]=0, sclk=cpol, state=LEAD.
  - If cpha=0, mosi = bit N-1 on the same edge.
- Latched parameters hold for the whole frame. Changes to req, tx_*, clk_div, cpol or cpha mid-frame have no effect.
- LEAD: H cycles, sclk idle.
- SHIFT: 2N SCLK edges, one every H cycles. Odd edges are leading (sclk=!cpol); even edges are trailing (sclk=cpol).
  - cpha=0: sample miso on leading edges; shift mosi to next bit on trailing edges, except after the last bit.
  - cpha=1: drive mosi on leading edges; sample miso on trailing edges.
  - miso is sampled on the clk edge that produces the SCLK edge.
- TRAIL: H cycles, sclk idle, mosi held.
- TRAIL exit: cs_b[g]=1, rx_valid=1 for one cycle, rx_ch=g, rx_data = N sampled bits (first sampled bit at position N-1, upper bits 0). state=GAP.
- GAP: H cycles, all cs_b high, then IDLE. A new grant is possible in the IDLE cycle after GAP.
- Frame timing: cs_b low for exactly (2N+2)*H cycles. Minimum spacing between back-to-back frames is H+1 cycles of cs_b high.
- Round-robin pointer updates on grant only.
- Requests with tx_len >= FRAME_W are clamped to FRAME_W-1.
- Simultaneous req: only one ack per grant. Unserved requests stay pending with no loss.
- rx_data holds its value until the next rx_valid.

Test Plan:
1. Mode 0, div 0, ch0, N=40, tx=0xA5_1234_5678, miso looped to mosi -> ack[0] on cycle 1, 40 rising sclk edges, cs_b[0] low 82 cycles, rx_valid with rx_data=0xA5_1234_5678, rx_ch=0.
2. Mode 3 (cpol=1, cpha=1), div=3, ch1, N=8, tx=0x3C -> sclk idles high, half-period 4 cycles, cs_b[1] low 72 cycles, mosi changes on falling edges, rx loopback=0x3C with upper bits zero.
3. req=2'b11 held, four frames -> grant order 0,1,0,1. Each ack is a single pulse. cs_b never both low. Gap between frames is H+1 cycles.
4. N=1, mode 1, miso tied 1 -> 2 sclk edges, rx_data=1, cs_b low 4*H cycles.
5. Assert rst at the 10th sclk edge of a 40-bit frame -> cs_b all high, sclk=0, busy=0 immediately, no rx_valid. A fresh request after release completes normally.
6. Change clk_div, cpol and tx_data mid-frame -> frame timing and data unchanged. New values take effect only on the next grant.
